// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake for clk_div_ctrl.
// The master offers cfg_div with cfg_valid; the slave accepts it when cfg_ready is high.
interface clk_div_ctrl_if #(
  parameter int DIV_W = 8
) ();
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with start/stop sequencing and a divisor config port.
// Divisor and stop changes land only on period boundaries, so clk_out never has runt pulses.
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  clk_div_ctrl_if.slave cfg,
  output logic          clk_out,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic          running,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN_HI,
    S_RUN_LO
  } state_t;

  localparam logic [DIV_W-1:0] LP_DEF = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] LP_TWO = DIV_W'(2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_active_div;
  logic [DIV_W-1:0] w_active_nxt;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] w_pend_nxt;
  logic             r_pend_full;
  logic             w_pend_full_nxt;
  logic             r_stop_pend;
  logic             w_stop_pend_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             w_clk_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_cfg_err;
  logic             w_err_nxt;

  logic             w_cfg_ready;
  logic             w_xfer;
  logic             w_legal;
  logic [DIV_W-1:0] w_hi_len;
  logic [DIV_W-1:0] w_lo_len;
  logic             w_hi_last;
  logic             w_lo_last;

  assign w_cfg_ready = ~r_pend_full;
  assign w_xfer      = cfg.cfg_valid & w_cfg_ready;
  assign w_legal     = cfg.cfg_div >= LP_TWO;
  assign w_hi_len    = r_active_div >> 1;
  assign w_lo_len    = r_active_div - w_hi_len;
  assign w_hi_last   = r_cnt == (w_hi_len - LP_ONE);
  assign w_lo_last   = r_cnt == (w_lo_len - LP_ONE);

  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active_div;
    w_pend_nxt      = r_pend_div;
    w_pend_full_nxt = r_pend_full;
    w_stop_pend_nxt = r_stop_pend;
    w_cnt_nxt       = r_cnt;
    w_clk_nxt       = r_clk_out;
    w_rise_nxt      = 1'b0;
    w_fall_nxt      = 1'b0;
    w_err_nxt       = w_xfer & ~w_legal;

    unique case (r_state)
      S_IDLE: begin
        w_clk_nxt       = 1'b0;
        w_stop_pend_nxt = 1'b0;
        // A value parked on the stopping boundary edge lands here.
        if (r_pend_full) begin
          w_active_nxt    = r_pend_div;
          w_pend_full_nxt = 1'b0;
        end
        if (w_xfer && w_legal) begin
          w_active_nxt = cfg.cfg_div;
        end
        if (start && !stop) begin
          w_state_nxt = S_RUN_HI;
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
        end
      end

      S_RUN_HI: begin
        if (stop) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (w_xfer && w_legal) begin
          w_pend_nxt      = cfg.cfg_div;
          w_pend_full_nxt = 1'b1;
        end
        if (w_hi_last) begin
          w_state_nxt = S_RUN_LO;
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end

      S_RUN_LO: begin
        if (stop) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (w_xfer && w_legal) begin
          w_pend_nxt      = cfg.cfg_div;
          w_pend_full_nxt = 1'b1;
        end
        if (w_lo_last) begin
          w_cnt_nxt = '0;
          // Period boundary: only place active_div may change while running.
          if (r_pend_full) begin
            w_active_nxt    = r_pend_div;
            w_pend_full_nxt = 1'b0;
          end
          if (r_stop_pend || stop) begin
            w_state_nxt     = S_IDLE;
            w_stop_pend_nxt = 1'b0;
            w_clk_nxt       = 1'b0;
          end else begin
            w_state_nxt = S_RUN_HI;
            w_clk_nxt   = 1'b1;
            w_rise_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_active_div <= LP_DEF;
      r_pend_div   <= '0;
      r_pend_full  <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_cnt        <= '0;
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_div <= w_active_nxt;
      r_pend_div   <= w_pend_nxt;
      r_pend_full  <= w_pend_full_nxt;
      r_stop_pend  <= w_stop_pend_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clk_out    <= w_clk_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_cfg_err    <= w_err_nxt;
    end
  end

  assign cfg.cfg_ready = w_cfg_ready;
  assign clk_out       = r_clk_out;
  assign rise_tick     = r_rise;
  assign fall_tick     = r_fall;
  assign running       = r_state != S_IDLE;
  assign cfg_err       = r_cfg_err;

endmodule
